fwd_scoreboard: RTL
===================

# fwd_scoreboard

Parametrised operand-forwarding and load-use hazard unit for the EX stage of the pipelined CPU. It tracks destination tags of in-flight producers in its own shift register, so the pipeline no longer decodes per-stage control bits. It selects forwarded data for up to NUM_SRC source operands, with the youngest producer taking priority. It also asserts a one-cycle stall when a source depends on a load whose data is not yet available, and counts stall cycles.

## Interface
Parameters:
- DATA_W, 64, operand/result width
- REG_W, 5, register index width
- NUM_SRC, 2, number of source operand channels
- DEPTH, 3, tracked producer stages after EX (entry 0 = MEM, entry 1 = WB, entry 2 = post-WB)
- LOAD_RDY, 1, lowest entry index at which a load's result is valid in stage_data
- ZERO_REG, 31, hardwired-zero register index, never forwarded

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- ex_valid  in  1  EX slot holds a real instruction
- ex_src  in  NUM_SRC*REG_W  source register indices, channel i at [i*REG_W +: REG_W]
- ex_src_data  in  NUM_SRC*DATA_W  register-file read data per channel
- ex_wr_en  in  1  EX instruction writes a register
- ex_dst  in  REG_W  EX instruction destination
- ex_is_load  in  1  EX instruction is a load
- stage_data  in  DEPTH*DATA_W  result currently held by the producer in entry k
- out  out  NUM_SRC*DATA_W  resolved operand per channel
- fwd_hit  out  NUM_SRC  channel i uses forwarded data
- stall  out  1  hold EX and earlier stages this cycle
- stall_cnt  out  16  saturating count of stall cycles

## Operation
- State: DEPTH entries, each {vld, dst[REG_W-1:0], ld}.
- Entry write condition: vld is set only if ex_valid & ex_wr_en & (ex_dst != ZERO_REG).
- Match for channel i, entry k: entry.vld & (entry.dst == src_i) & (src_i != ZERO_REG).
- Selection per channel: the lowest matching k wins (youngest producer).
  - No match: out_i = ex_src_data_i, fwd_hit_i = 0.
  - Winning entry has ld = 1 and k < LOAD_RDY: the channel is "not ready". out_i = ex_src_data_i and fwd_hit_i = 0 for that cycle.
  - Otherwise: out_i = stage_data[k], fwd_hit_i = 1.
- stall = ex_valid & (any channel not ready).
- Shift on every cycle without reset:
  - entry k <- entry k-1 for k ≥ 1.
  - entry 0 <- {write condition, ex_dst, ex_is_load} when stall = 0.
  - entry 0 <- bubble (vld = 0) when stall = 0 does not hold.
  - Older entries keep draining during a stall.
- stall_cnt increments by 1 each cycle stall = 1 and saturates at 16'hFFFF.
- The pipeline must advance MEM/WB in lockstep with this shift and hold the EX slot while stall = 1. This keeps stage_data[k] aligned with entry k.
- Boundary cases:
  - ex_valid = 0: no stall and no match effect on state, but lookups still drive out.
  - A load matched only at k ≥ LOAD_RDY does not stall.
  - If a non-load and a not-ready load both match, the younger one decides.
  - Reset mid-stall clears all entries. The next cycle shows no stall.

## Timing
- out, fwd_hit and stall are combinational from the current entries, ex_* and stage_data. There is zero-cycle latency.
- Entries and stall_cnt update on the rising edge.
- Load-use with LOAD_RDY = 1: the dependent instruction stalls exactly 1 cycle, then forwards from entry 1.
- Reset values: all entries vld = 0, stall_cnt = 0. During and right after reset, stall = 0, fwd_hit = 0 and out = ex_src_data.

## Test plan
- ALU chain: ADD X1 issues, then SUB with src0 = X1 the next cycle, stage_data[0] = 64'h5 → out0 = 5, fwd_hit = 2'b01, stall = 0.
- Priority: X2 is in entry 0 (data 64'hA) and entry 1 (data 64'hB), src1 = X2 → out1 = 64'hA.
- Load-use: LDUR X3 then ADD src0 = X3:
  - first cycle: stall = 1, stall_cnt = 1;
  - next cycle: entry 1 matches, out0 = stage_data[1], stall = 0.
- Zero register: producer writes X31 and src0 = 31 with ex_src_data = 0 → out0 = 0, fwd_hit = 0, no entry allocated.
- Reset mid-operation: assert reset during a load-use stall → the next cycle has stall = 0, stall_cnt = 0, fwd_hit = 0.
- Saturation: hold a not-ready load dependency artificially (force stage shift inputs) for 70000 cycles → stall_cnt stays 16'hFFFF.

Source files
------------

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: EX-stage operand forwarding and load-use hazard unit
//   clk, reset    : clock, synchronous active-high reset
//   ex_*          : EX-slot instruction (valid, sources, rf data, dest, load flag)
//   stage_data    : result held by the producer tracked in entry k
//   out, fwd_hit  : resolved operand per channel, and whether it was forwarded
//   stall         : hold EX and earlier this cycle (load result not yet valid)
//   stall_cnt     : saturating count of stall cycles
module fwd_scoreboard #(
    parameter int DATA_W   = 64,
    parameter int REG_W    = 5,
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 3,
    parameter int LOAD_RDY = 1,
    parameter int ZERO_REG = 31
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ex_valid,
    input  logic [NUM_SRC*REG_W-1:0]    ex_src,
    input  logic [NUM_SRC*DATA_W-1:0]   ex_src_data,
    input  logic                        ex_wr_en,
    input  logic [REG_W-1:0]            ex_dst,
    input  logic                        ex_is_load,
    input  logic [DEPTH*DATA_W-1:0]     stage_data,
    output logic [NUM_SRC*DATA_W-1:0]   out,
    output logic [NUM_SRC-1:0]          fwd_hit,
    output logic                        stall,
    output logic [15:0]                 stall_cnt
);
    localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);
    logic [DEPTH-1:0]       vld;
    logic [DEPTH-1:0]       ld;
    logic [DEPTH*REG_W-1:0] dst;
    logic [NUM_SRC-1:0]     nrdy;
    logic                   alloc;
    // Scan oldest to youngest so the youngest match overwrites; reset masks all matches.
    always_comb begin
        out = ex_src_data;
        fwd_hit = '0;
        nrdy = '0;
        for (int i = 0; i < NUM_SRC; i++)
            for (int k = DEPTH-1; k >= 0; k--)
                if (!reset && vld[k] && dst[k*REG_W +: REG_W] == ex_src[i*REG_W +: REG_W]
                    && ex_src[i*REG_W +: REG_W] != ZR) begin
                    nrdy[i] = ld[k] && (k < LOAD_RDY);
                    fwd_hit[i] = !nrdy[i];
                    out[i*DATA_W +: DATA_W] = nrdy[i] ? ex_src_data[i*DATA_W +: DATA_W]
                                                      : stage_data[k*DATA_W +: DATA_W];
                end
    end
    assign stall = ex_valid && (|nrdy);
    // A stalled EX slot enters the shift as a bubble; older entries keep draining.
    assign alloc = !stall && ex_valid && ex_wr_en && (ex_dst != ZR);
    always_ff @(posedge clk)
        if (reset) begin
            vld       <= '0;
            ld        <= '0;
            dst       <= '0;
            stall_cnt <= '0;
        end else begin
            vld       <= (vld << 1) | DEPTH'(alloc);
            ld        <= (ld << 1) | DEPTH'(ex_is_load);
            dst       <= (dst << REG_W) | (DEPTH*REG_W)'(ex_dst);
            stall_cnt <= stall_cnt + {15'd0, stall && (stall_cnt != 16'hFFFF)};
        end
endmodule
